// File: rtl/jt12_kon_pkg.sv
// Shared types and helpers for the key-on write sequencer.
package jt12_kon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } kon_state_t;

    // Slot counter operator value at which the shifter applies an update.
    localparam logic [1:0] KON_OP_LAST = 2'd3;

    // Channel code 3 (and 7) never exist; upper bank only exists with 6 channels.
    function automatic logic kon_ch_valid(input logic [2:0] code, input int nch);
        logic ok;
        ok = (code[1:0] != 2'b11);
        if (nch == 3) begin
            ok = ok && (code[2] == 1'b0);
        end
        return ok;
    endfunction

endpackage

// File: rtl/jt12_kon_fifo.sv
// Small synchronous FIFO advancing only on clk_en; a pop frees a slot for a same-edge push.
import jt12_kon_pkg::*;

module jt12_kon_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty     = (count_r == (AW+1)'(0));
    assign full      = (count_r == FULL_CNT);
    assign dout      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clk_en) begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/jt12_kon_wr.sv
// Key-on write sequencer: decodes register 0x28 writes, queues them and hands
// them one at a time to the key-on shifter, waiting for the applying slot.
import jt12_kon_pkg::*;

module jt12_kon_wr #(
    parameter int num_ch = 6,
    parameter int depth  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       wr_en,
    input  logic [7:0] din,
    input  logic [1:0] next_op,
    input  logic [2:0] next_ch,
    input  logic       clr_ovf,
    output logic       up_keyon,
    output logic [3:0] keyon_op,
    output logic [2:0] keyon_ch,
    output logic       busy,
    output logic       ovf
);
    kon_state_t state_r;
    kon_state_t state_next_s;
    logic       push_s;
    logic       pop_s;
    logic       full_s;
    logic       empty_s;
    logic [6:0] head_s;
    logic       slot_match_s;
    logic       up_keyon_r;
    logic [3:0] keyon_op_r;
    logic [2:0] keyon_ch_r;
    logic       ovf_r;
    logic       din_unused_s;

    assign din_unused_s = din[3];
    assign push_s       = wr_en && kon_ch_valid(din[2:0], num_ch);
    assign slot_match_s = (next_ch == keyon_ch_r) && (next_op == KON_OP_LAST);

    jt12_kon_fifo #(
        .WIDTH (7),
        .DEPTH (depth)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .push   (push_s),
        .pop    (pop_s),
        .din    ({din[7:4], din[2:0]}),
        .dout   (head_s),
        .full   (full_s),
        .empty  (empty_s)
    );

    // Next-state decode; the head is popped on the edge that enters ISSUE.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    state_next_s = ISSUE;
                    pop_s        = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            // A slot match on this edge is ignored: the shifter has only just
            // latched the request and applies it on the next matching slot.
            ISSUE: state_next_s = WAIT;
            WAIT: begin
                if (slot_match_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register and registered request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            up_keyon_r <= 1'b0;
            keyon_op_r <= 4'd0;
            keyon_ch_r <= 3'd0;
        end else if (clk_en) begin
            state_r    <= state_next_s;
            up_keyon_r <= (state_next_s == ISSUE);
            if (pop_s) begin
                keyon_op_r <= head_s[6:3];
                keyon_ch_r <= head_s[2:0];
            end
        end
    end

    // Sticky overflow flag; a dropped write wins over a same-edge clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (clk_en) begin
            if (push_s && full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end else if (clr_ovf) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign up_keyon = up_keyon_r;
    assign keyon_op = keyon_op_r;
    assign keyon_ch = keyon_ch_r;
    assign ovf      = ovf_r;
    assign busy     = !empty_s || (state_r != IDLE);

endmodule

// File: tb/tb_jt12_kon_wr.sv
// Directed bench for jt12_kon_wr: one 6-channel and one 3-channel instance
// share the same stimulus.
module tb_jt12_kon_wr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic       wr_en;
    logic [7:0] din;
    logic [1:0] next_op;
    logic [2:0] next_ch;
    logic       clr_ovf;

    logic       up6, busy6, ovf6;
    logic [3:0] op6;
    logic [2:0] ch6;
    logic       up3, busy3, ovf3;
    logic [3:0] op3;
    logic [2:0] ch3;

    int checks   = 0;
    int failures = 0;
    int pulses;

    logic [7:0] ovf_vals [6];

    always #5 clk = ~clk;

    jt12_kon_wr #(.num_ch(6), .depth(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_en(wr_en), .din(din),
        .next_op(next_op), .next_ch(next_ch), .clr_ovf(clr_ovf),
        .up_keyon(up6), .keyon_op(op6), .keyon_ch(ch6), .busy(busy6), .ovf(ovf6)
    );

    jt12_kon_wr #(.num_ch(3), .depth(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_en(wr_en), .din(din),
        .next_op(next_op), .next_ch(next_ch), .clr_ovf(clr_ovf),
        .up_keyon(up3), .keyon_op(op3), .keyon_ch(ch3), .busy(busy3), .ovf(ovf3)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Current request waits through a non-matching slot, is released by the
    // prev channel's op-3 slot, then the next entry must issue.
    task automatic drain(input string tag, input logic [2:0] prev,
                         input logic [2:0] exp_ch, input logic [3:0] exp_op);
        next_op = 2'd0;
        tick();
        chk({tag, "_gap"}, {7'd0, up6}, 8'd0);
        next_ch = prev;
        next_op = 2'd3;
        tick();
        next_op = 2'd0;
        tick();
        chk({tag, "_up"}, {7'd0, up6}, 8'd1);
        chk({tag, "_ch"}, {5'd0, ch6}, {5'd0, exp_ch});
        chk({tag, "_op"}, {4'd0, op6}, {4'd0, exp_op});
    endtask

    // Let the last issued request reach its slot and check the block goes idle.
    task automatic finish_q(input string tag, input logic [2:0] prev);
        next_op = 2'd0;
        tick();
        next_ch = prev;
        next_op = 2'd3;
        tick();
        next_op = 2'd0;
        chk({tag, "_idle"}, {7'd0, busy6}, 8'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        clk_en  = 1'b1;
        wr_en   = 1'b0;
        din     = 8'h00;
        next_op = 2'd0;
        next_ch = 3'd0;
        clr_ovf = 1'b0;
        ovf_vals[0] = 8'h11; ovf_vals[1] = 8'h21; ovf_vals[2] = 8'h41;
        ovf_vals[3] = 8'h81; ovf_vals[4] = 8'h12; ovf_vals[5] = 8'h14;

        // Reset state
        tick();
        tick();
        chk("rst_up",   {7'd0, up6},   8'd0);
        chk("rst_op",   {4'd0, op6},   8'd0);
        chk("rst_ch",   {5'd0, ch6},   8'd0);
        chk("rst_busy", {7'd0, busy6}, 8'd0);
        chk("rst_ovf",  {7'd0, ovf6},  8'd0);
        rst_n = 1'b1;
        tick();

        // Single write 0xF1
        wr_en = 1'b1; din = 8'hF1;
        tick();
        wr_en = 1'b0;
        chk("sw_no_early_up", {7'd0, up6},   8'd0);
        chk("sw_busy",        {7'd0, busy6}, 8'd1);
        tick();
        chk("sw_up", {7'd0, up6}, 8'd1);
        chk("sw_op", {4'd0, op6}, 8'h0F);
        chk("sw_ch", {5'd0, ch6}, 8'd1);
        tick();
        chk("sw_up_one_period", {7'd0, up6},   8'd0);
        chk("sw_busy_wait",     {7'd0, busy6}, 8'd1);
        next_ch = 3'd1; next_op = 2'd2;
        tick();
        chk("sw_busy_op2", {7'd0, busy6}, 8'd1);
        next_op = 2'd3; clk_en = 1'b0;
        tick();
        tick();
        chk("sw_hold_clken0", {7'd0, busy6}, 8'd1);
        chk("sw_op_hold",     {4'd0, op6},   8'h0F);
        clk_en = 1'b1;
        tick();
        chk("sw_busy_fall", {7'd0, busy6}, 8'd0);
        next_op = 2'd0;

        // Slot match coinciding with the ISSUE->WAIT edge is ignored
        wr_en = 1'b1; din = 8'h52;
        tick();
        wr_en = 1'b0;
        tick();
        chk("em_up", {7'd0, up6}, 8'd1);
        chk("em_ch", {5'd0, ch6}, 8'd2);
        next_ch = 3'd2; next_op = 2'd3;
        tick();
        chk("em_ignored", {7'd0, busy6}, 8'd1);
        next_op = 2'd0;
        tick();
        chk("em_still_wait", {7'd0, busy6}, 8'd1);
        next_op = 2'd3;
        tick();
        chk("em_released", {7'd0, busy6}, 8'd0);
        next_op = 2'd0;

        // Burst 0x10, 0x24, 0x46, 0x82 on consecutive edges
        wr_en = 1'b1; din = 8'h10;
        tick();
        din = 8'h24;
        tick();
        chk("bu0_up", {7'd0, up6}, 8'd1);
        chk("bu0_ch", {5'd0, ch6}, 8'd0);
        chk("bu0_op", {4'd0, op6}, 8'd1);
        din = 8'h46;
        tick();
        din = 8'h82;
        tick();
        wr_en = 1'b0;
        drain("bu1", 3'd0, 3'd4, 4'h2);
        drain("bu2", 3'd4, 3'd6, 4'h4);
        drain("bu3", 3'd6, 3'd2, 4'h8);
        finish_q("bu", 3'd2);

        // Overflow: 6 writes while stuck in WAIT, clear on the 6th edge too
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; din = ovf_vals[i];
            clr_ovf = (i == 5);
            tick();
            if (i == 4) chk("ovf_not_yet", {7'd0, ovf6}, 8'd0);
        end
        wr_en = 1'b0; clr_ovf = 1'b0;
        chk("ovf_set_over_clr", {7'd0, ovf6}, 8'd1);
        tick(); tick(); tick();
        chk("ovf_sticky", {7'd0, ovf6}, 8'd1);
        clk_en = 1'b0; clr_ovf = 1'b1;
        tick();
        chk("ovf_clr_clken0", {7'd0, ovf6}, 8'd1);
        clk_en = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", {7'd0, ovf6}, 8'd0);
        // Full queue: a push on the popping edge must succeed
        next_ch = 3'd1; next_op = 2'd3;
        tick();
        next_op = 2'd0; wr_en = 1'b1; din = 8'h31;
        tick();
        wr_en = 1'b0;
        chk("fp_ovf",   {7'd0, ovf6}, 8'd0);
        chk("fp_up",    {7'd0, up6},  8'd1);
        chk("fp_op",    {4'd0, op6},  8'd2);
        chk("fp_ch",    {5'd0, ch6},  8'd1);
        drain("fp1", 3'd1, 3'd1, 4'h4);
        drain("fp2", 3'd1, 3'd1, 4'h8);
        drain("fp3", 3'd1, 3'd2, 4'h1);
        drain("fp4", 3'd2, 3'd1, 4'h3);
        finish_q("fp", 3'd1);

        // Reset mid-WAIT with 2 entries queued
        wr_en = 1'b1; din = 8'h11;
        tick();
        din = 8'h22;
        tick();
        din = 8'h44;
        tick();
        wr_en = 1'b0;
        chk("mr_busy_before", {7'd0, busy6}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_up",   {7'd0, up6},   8'd0);
        chk("mr_op",   {4'd0, op6},   8'd0);
        chk("mr_ch",   {5'd0, ch6},   8'd0);
        chk("mr_busy", {7'd0, busy6}, 8'd0);
        chk("mr_ovf",  {7'd0, ovf6},  8'd0);
        rst_n = 1'b1;
        pulses = 0;
        next_op = 2'd3;
        for (int i = 0; i < 10; i++) begin
            next_ch = 3'(i % 7);
            tick();
            if (up6) pulses++;
        end
        next_op = 2'd0;
        chk("mr_no_pulse", 8'(pulses), 8'd0);
        chk("mr_idle", {7'd0, busy6}, 8'd0);

        // Invalid channel codes
        pulses = 0;
        wr_en = 1'b1; din = 8'hF3;
        tick();
        if (up6 || up3) pulses++;
        din = 8'hF7;
        tick();
        if (up6 || up3) pulses++;
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (up6 || up3) pulses++;
        end
        chk("inv_no_pulse", 8'(pulses), 8'd0);
        chk("inv_busy6", {7'd0, busy6}, 8'd0);
        chk("inv_ovf6",  {7'd0, ovf6},  8'd0);
        chk("inv_busy3", {7'd0, busy3}, 8'd0);
        wr_en = 1'b1; din = 8'hF4;
        tick();
        wr_en = 1'b0;
        chk("inv3_busy_f4", {7'd0, busy3}, 8'd0);
        tick();
        chk("inv3_up_f4",  {7'd0, up3},  8'd0);
        chk("inv3_ovf_f4", {7'd0, ovf3}, 8'd0);
        chk("ch4_up6_f4",  {7'd0, up6},  8'd1);
        chk("ch4_ch6_f4",  {5'd0, ch6},  8'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
